// File: rtl/entry_sequencer.sv
// entry_sequencer: button-driven multi-field value entry controller.
// Ports: clk, rst (async low); btn_sel/btn_next/btn_cancel pulses;
//   sw live field; cur_data pre-load; busy, active_tgt, step status;
//   commit/commit_tgt/commit_data write strobe; timeout abort pulse.
module entry_sequencer #(
  parameter int N_TGT = 3,
  parameter int N_STEP = 3,
  parameter int FIELD_W = 7,
  parameter logic [4*N_TGT-1:0] STEPS_VEC = {4'd2, 4'd3, 4'd2},
  parameter int TIMEOUT_CYC = 0,
  localparam int TGT_W = (N_TGT > 1) ? $clog2(N_TGT) : 1,
  localparam int STEP_W = (N_STEP > 1) ? $clog2(N_STEP) : 1,
  localparam int DATA_W = N_STEP * FIELD_W,
  localparam int CNT_W =
    (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_TGT-1:0]  btn_sel,
  input  logic              btn_next,
  input  logic              btn_cancel,
  input  logic [FIELD_W-1:0] sw,
  input  logic [DATA_W-1:0] cur_data,
  output logic              busy,
  output logic [TGT_W-1:0]  active_tgt,
  output logic [STEP_W-1:0] step,
  output logic              commit,
  output logic [TGT_W-1:0]  commit_tgt,
  output logic [DATA_W-1:0] commit_data,
  output logic              timeout
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_ENTER  = 2'd2;
  localparam logic [1:0] S_COMMIT = 2'd3;

  // Steps for target t: 0 means 1, anything above N_STEP clamps.
  function automatic int steps_of(input int t);
    int raw;
    raw = int'(STEPS_VEC[4*t +: 4]);
    if (raw == 0) raw = 1;
    if (raw > N_STEP) raw = N_STEP;
    return raw;
  endfunction

  logic [1:0]        state;
  logic [DATA_W-1:0] buffer;
  logic [CNT_W-1:0]  cnt;

  logic [TGT_W-1:0]  sel_idx;
  logic [STEP_W-1:0] last_step;
  logic [DATA_W-1:0] buf_nxt;
  logic              at_last;
  logic              to_hit;

  // Lowest set btn_sel bit wins.
  always_comb begin
    sel_idx = '0;
    for (int t = N_TGT - 1; t >= 0; t--) begin
      if (btn_sel[t]) sel_idx = TGT_W'(t);
    end
  end

  always_comb begin
    last_step = '0;
    for (int t = 0; t < N_TGT; t++) begin
      if (active_tgt == TGT_W'(t)) begin
        last_step = STEP_W'(steps_of(t) - 1);
      end
    end
  end

  // Live sw overlays only the field under edit.
  always_comb begin
    buf_nxt = buffer;
    for (int k = 0; k < N_STEP; k++) begin
      if (step == STEP_W'(k)) begin
        buf_nxt[k*FIELD_W +: FIELD_W] = sw;
      end
    end
  end

  assign at_last = (step == last_step);
  assign to_hit = (TIMEOUT_CYC != 0) &&
                  (cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      buffer      <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      active_tgt  <= '0;
      step        <= '0;
      commit      <= 1'b0;
      commit_tgt  <= '0;
      commit_data <= '0;
      timeout     <= 1'b0;
    end else begin
      commit  <= 1'b0;
      timeout <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (|btn_sel) begin
            active_tgt <= sel_idx;
            state      <= S_LOAD;
            busy       <= 1'b1;
          end
        end
        S_LOAD: begin
          buffer <= cur_data;
          step   <= '0;
          cnt    <= '0;
          state  <= S_ENTER;
        end
        S_ENTER: begin
          buffer <= buf_nxt;
          if (btn_cancel) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (btn_next) begin
            if (at_last) begin
              state       <= S_COMMIT;
              commit      <= 1'b1;
              commit_tgt  <= active_tgt;
              commit_data <= buf_nxt;
            end else begin
              step <= step + 1'b1;
              cnt  <= '0;
            end
          end else if (to_hit) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            timeout <= 1'b1;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        S_COMMIT: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_entry_sequencer.sv
// tb_entry_sequencer: scoreboard bench for entry_sequencer.
// Drives a default instance and a TIMEOUT_CYC=100 instance.
module tb_entry_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  btn_sel = '0;
  logic        btn_next = 1'b0;
  logic        btn_cancel = 1'b0;
  logic [6:0]  sw = '0;
  logic [20:0] cur_data = '0;

  logic        busy, commit, timeout;
  logic [1:0]  active_tgt, step, commit_tgt;
  logic [20:0] commit_data;

  logic        busy_t, commit_t, timeout_t;
  logic [1:0]  active_tgt_t, step_t, commit_tgt_t;
  logic [20:0] commit_data_t;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [1:0]  tgt;
    logic [20:0] data;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  entry_sequencer dut (
    .clk(clk), .rst(rst),
    .btn_sel(btn_sel), .btn_next(btn_next),
    .btn_cancel(btn_cancel), .sw(sw),
    .cur_data(cur_data), .busy(busy),
    .active_tgt(active_tgt), .step(step),
    .commit(commit), .commit_tgt(commit_tgt),
    .commit_data(commit_data), .timeout(timeout)
  );

  entry_sequencer #(.TIMEOUT_CYC(100)) dut_t (
    .clk(clk), .rst(rst),
    .btn_sel(btn_sel), .btn_next(btn_next),
    .btn_cancel(btn_cancel), .sw(sw),
    .cur_data(cur_data), .busy(busy_t),
    .active_tgt(active_tgt_t), .step(step_t),
    .commit(commit_t), .commit_tgt(commit_tgt_t),
    .commit_data(commit_data_t), .timeout(timeout_t)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst && commit) begin
      check("sb_avail", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("sb_tgt", 64'(commit_tgt), 64'(e.tgt));
        check("sb_data", 64'(commit_data), 64'(e.data));
      end
    end
    if (rst && timeout) check("to_disabled", 64'(timeout), 0);
  end

  task automatic run_entry(input logic [2:0] sel,
                           input logic [20:0] cur,
                           input logic [6:0] f0,
                           input logic [6:0] f1,
                           input logic [6:0] f2);
    logic [6:0] f [3];
    int t;
    int n;
    exp_t e;
    f[0] = f0;
    f[1] = f1;
    f[2] = f2;
    t = 0;
    for (int i = 2; i >= 0; i--) if (sel[i]) t = i;
    n = (t == 1) ? 3 : 2;
    e.tgt = 2'(t);
    e.data = cur;
    for (int i = 0; i < n; i++) e.data[i*7 +: 7] = f[i];
    cur_data = cur;
    btn_sel = sel;
    tick();
    btn_sel = '0;
    check("busy_load", 64'(busy), 1);
    check("tgt_load", 64'(active_tgt), 64'(t));
    tick();
    check("step0", 64'(step), 0);
    for (int i = 0; i < n; i++) begin
      sw = f[i];
      btn_next = 1'b1;
      if (i == n - 1) sb.push_back(e);
      tick();
      btn_next = 1'b0;
      if (i < n - 1) check("step_adv", 64'(step), 64'(i + 1));
    end
    check("commit_lat", 64'(commit), 1);
    check("busy_commit", 64'(busy), 1);
    tick();
    check("commit_1cyc", 64'(commit), 0);
    check("busy_fall", 64'(busy), 0);
    check("data_hold", 64'(commit_data), 64'(e.data));
  endtask

  initial begin
    #2;
    check("rst_busy", 64'(busy), 0);
    check("rst_commit", 64'(commit), 0);
    check("rst_data", 64'(commit_data), 0);
    tick();
    rst = 1'b1;
    tick();

    run_entry(3'b001, 21'h0, 7'd13, 7'd45, 7'd0);
    run_entry(3'b010, {7'd99, 14'd0}, 7'd22, 7'd1, 7'd21);
    check("t2_data", 64'(commit_data),
          64'({7'd21, 7'd1, 7'd22}));
    run_entry(3'b100, {7'd99, 7'd8, 7'd9}, 7'd5, 7'd6, 7'd0);
    check("t3_keep", 64'(commit_data[20:14]), 64'd99);

    // Simultaneous select, then cancel mid-entry.
    cur_data = '0;
    btn_sel = 3'b110;
    tick();
    btn_sel = '0;
    check("sel_prio", 64'(active_tgt), 1);
    tick();
    sw = 7'd3;
    btn_next = 1'b1;
    tick();
    btn_next = 1'b0;
    btn_sel = 3'b001;
    tick();
    btn_sel = '0;
    check("sel_ignored", 64'(active_tgt), 1);
    check("cancel_step", 64'(step), 1);
    btn_cancel = 1'b1;
    tick();
    btn_cancel = 1'b0;
    check("cancel_busy", 64'(busy), 0);
    check("cancel_commit", 64'(commit), 0);
    repeat (4) tick();
    check("cancel_quiet", 64'(busy), 0);

    // next + cancel together on last step.
    btn_sel = 3'b001;
    tick();
    btn_sel = '0;
    tick();
    btn_next = 1'b1;
    tick();
    btn_cancel = 1'b1;
    tick();
    btn_next = 1'b0;
    btn_cancel = 1'b0;
    check("nc_busy", 64'(busy), 0);
    check("nc_commit", 64'(commit), 0);
    check("nc_commit_t", 64'(commit_t), 0);
    tick();

    // Timeout with no buttons.
    btn_sel = 3'b001;
    tick();
    btn_sel = '0;
    tick();
    repeat (99) tick();
    check("to_pre_busy", 64'(busy_t), 1);
    check("to_pre_pulse", 64'(timeout_t), 0);
    tick();
    check("to_pulse", 64'(timeout_t), 1);
    check("to_busy", 64'(busy_t), 0);
    check("to_nocommit", 64'(commit_t), 0);
    check("to_dis_busy", 64'(busy), 1);
    tick();
    check("to_once", 64'(timeout_t), 0);
    btn_cancel = 1'b1;
    tick();
    btn_cancel = 1'b0;
    tick();

    // btn_next at counter 99 restarts the count.
    btn_sel = 3'b010;
    tick();
    btn_sel = '0;
    tick();
    repeat (99) tick();
    btn_next = 1'b1;
    tick();
    btn_next = 1'b0;
    check("tn_busy", 64'(busy_t), 1);
    check("tn_pulse", 64'(timeout_t), 0);
    check("tn_step", 64'(step_t), 1);
    repeat (99) tick();
    check("tn_pre", 64'(busy_t), 1);
    tick();
    check("tn_pulse2", 64'(timeout_t), 1);
    check("tn_busy2", 64'(busy_t), 0);
    btn_cancel = 1'b1;
    tick();
    btn_cancel = 1'b0;
    tick();

    // Reset mid-entry at step 1.
    btn_sel = 3'b010;
    tick();
    btn_sel = '0;
    tick();
    btn_next = 1'b1;
    tick();
    btn_next = 1'b0;
    check("pre_rst_step", 64'(step), 1);
    rst = 1'b0;
    #1;
    check("mr_busy", 64'(busy), 0);
    check("mr_step", 64'(step), 0);
    check("mr_tgt", 64'(active_tgt), 0);
    check("mr_ctgt", 64'(commit_tgt), 0);
    check("mr_data", 64'(commit_data), 0);
    check("mr_commit", 64'(commit), 0);
    check("mr_to", 64'(timeout_t), 0);
    tick();
    rst = 1'b1;
    tick();
    run_entry(3'b100, 21'h0, 7'd7, 7'd127, 7'd0);

    repeat (3) tick();
    check("sb_empty", 64'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
